// File: rtl/floating_point_adder.sv
// Multi-cycle binary32 adder/subtractor with a start/valid handshake.
// Truncating arithmetic; subnormal inputs are flushed to zero and reported as underflow.
module floating_point_adder (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] result,
    output logic        valid,
    output logic        overflow,
    output logic        underflow
);

    // Handshake: start is sampled only in IDLE on a rising edge. valid is a
    // one-cycle pulse. result/overflow/underflow change only with that pulse
    // and hold until the next one.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] QNAN = 32'hFF800001;

    state_t state;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        big_s;
    logic        sub_op;
    logic [7:0]  big_e;
    logic [7:0]  diff;
    logic [23:0] m_big;
    logic [23:0] m_small;
    logic [24:0] sum;
    logic [31:0] res_r;
    logic        ovf_r;
    logic        unf_r;

    // Operand classification for the UNPACK stage.
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        a_ge_b;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic        spec_unf;

    always_comb begin
        ea       = op_a[30:23];
        eb       = op_b[30:23];
        fa       = op_a[22:0];
        fb       = op_b[22:0];
        nan_a    = (ea == 8'hFF) && (fa != 23'd0);
        nan_b    = (eb == 8'hFF) && (fb != 23'd0);
        inf_a    = (ea == 8'hFF) && (fa == 23'd0);
        inf_b    = (eb == 8'hFF) && (fb == 23'd0);
        zero_a   = (ea == 8'd0);
        zero_b   = (eb == 8'd0);
        a_ge_b   = (op_a[30:0] >= op_b[30:0]);
        spec_hit = 1'b1;
        spec_res = 32'd0;
        spec_unf = 1'b0;
        if (nan_a || nan_b) begin
            spec_res = QNAN;
        end else if (inf_a && inf_b && (op_a[31] != op_b[31])) begin
            spec_res = QNAN;
        end else if (inf_a) begin
            spec_res = op_a;
        end else if (inf_b) begin
            spec_res = op_b;
        end else if (zero_a || zero_b) begin
            spec_unf = (zero_a && (fa != 23'd0)) || (zero_b && (fb != 23'd0));
            if (zero_a && zero_b) begin
                spec_res = (op_a[31] && op_b[31]) ? 32'h80000000 : 32'h00000000;
            end else if (zero_a) begin
                spec_res = op_b;
            end else begin
                spec_res = op_a;
            end
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Normalisation: single-cycle leading-one detect over the 24-bit sum.
    logic [4:0]        lz;
    logic              lz_found;
    logic [23:0]       shifted;
    logic signed [9:0] norm_e;
    logic [22:0]       norm_frac;
    logic [31:0]       norm_res;
    logic              norm_ovf;
    logic              norm_unf;

    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && sum[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
        shifted   = sum[23:0] << lz;
        norm_e    = 10'sd0;
        norm_frac = 23'd0;
        norm_res  = 32'd0;
        norm_ovf  = 1'b0;
        norm_unf  = 1'b0;
        if (sum[24]) begin
            norm_e    = $signed({2'b00, big_e}) + 10'sd1;
            norm_frac = sum[23:1];
        end else begin
            norm_e    = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
            norm_frac = shifted[22:0];
        end
        if (sum == 25'd0) begin
            norm_res = 32'h00000000;
        end else if (norm_e >= 10'sd255) begin
            norm_res = {big_s, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (norm_e <= 10'sd0) begin
            norm_res = {big_s, 31'd0};
            norm_unf = 1'b1;
        end else begin
            norm_res = {big_s, norm_e[7:0], norm_frac};
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            big_s     <= 1'b0;
            sub_op    <= 1'b0;
            big_e     <= 8'd0;
            diff      <= 8'd0;
            m_big     <= 24'd0;
            m_small   <= 24'd0;
            sum       <= 25'd0;
            res_r     <= 32'd0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            result    <= 32'd0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sub_op <= op_a[31] ^ op_b[31];
                    if (spec_hit) begin
                        res_r <= spec_res;
                        ovf_r <= 1'b0;
                        unf_r <= spec_unf;
                        state <= DONE;
                    end else begin
                        // Larger magnitude goes to the "big" lane and sets the sign.
                        if (a_ge_b) begin
                            big_s   <= op_a[31];
                            big_e   <= ea;
                            diff    <= ea - eb;
                            m_big   <= {1'b1, fa};
                            m_small <= {1'b1, fb};
                        end else begin
                            big_s   <= op_b[31];
                            big_e   <= eb;
                            diff    <= eb - ea;
                            m_big   <= {1'b1, fb};
                            m_small <= {1'b1, fa};
                        end
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    m_small <= (diff >= 8'd25) ? 24'd0 : (m_small >> diff);
                    state   <= ADD;
                end
                ADD: begin
                    sum   <= sub_op ? ({1'b0, m_big} - {1'b0, m_small})
                                    : ({1'b0, m_big} + {1'b0, m_small});
                    state <= NORM;
                end
                NORM: begin
                    res_r <= norm_res;
                    ovf_r <= norm_ovf;
                    unf_r <= norm_unf;
                    state <= DONE;
                end
                DONE: begin
                    result    <= res_r;
                    overflow  <= ovf_r;
                    underflow <= unf_r;
                    valid     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_adder.sv
// Bench for floating_point_adder: directed vectors plus random operands scored
// against an arithmetic reference model of truncating binary32 addition.
module tb_floating_point_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] result;
    logic        valid;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    // Expected {overflow, underflow, result} per issued operation.
    logic [33:0] exp_q[$];

    floating_point_adder dut (
        .clk(clk),
        .a(a),
        .b(b),
        .rst_n(rst_n),
        .start(start),
        .result(result),
        .valid(valid),
        .overflow(overflow),
        .underflow(underflow)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: returns {special, overflow, underflow, result}.
    function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        int unsigned ex, ey, eb, es, d;
        longint      mb, ms, s;
        int          e;
        logic        sx, sy, sb, nanx, nany, infx, infy, unf;
        logic [22:0] fx, fy;
        sx = x[31]; sy = y[31];
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0]; fy = y[22:0];
        nanx = (ex == 255) && (fx != 0);
        nany = (ey == 255) && (fy != 0);
        infx = (ex == 255) && (fx == 0);
        infy = (ey == 255) && (fy == 0);
        if (nanx || nany) return {3'b100, 32'hFF800001};
        if (infx && infy && (sx != sy)) return {3'b100, 32'hFF800001};
        if (infx) return {3'b100, x};
        if (infy) return {3'b100, y};
        if (ex == 0 || ey == 0) begin
            unf = ((ex == 0) && (fx != 0)) || ((ey == 0) && (fy != 0));
            if (ex == 0 && ey == 0) return {2'b10, unf, (sx && sy) ? 32'h80000000 : 32'h0};
            if (ex == 0) return {2'b10, unf, y};
            return {2'b10, unf, x};
        end
        if (x[30:0] >= y[30:0]) begin
            sb = sx; eb = ex; es = ey;
            mb = longint'(fx) + (64'd1 << 23); ms = longint'(fy) + (64'd1 << 23);
        end else begin
            sb = sy; eb = ey; es = ex;
            mb = longint'(fy) + (64'd1 << 23); ms = longint'(fx) + (64'd1 << 23);
        end
        d  = eb - es;
        ms = (d >= 25) ? 0 : (ms >> d);
        s  = (sx == sy) ? mb + ms : mb - ms;
        if (s == 0) return {3'b000, 32'h0};
        e = int'(eb);
        while (s >= (64'd1 << 24)) begin s = s >> 1; e++; end
        while (s < (64'd1 << 23)) begin s = s << 1; e--; end
        if (e >= 255) return {3'b010, sb, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, sb, 31'd0};
        return {3'b000, sb, 8'(e), s[22:0]};
    endfunction

    // Driver: issue one op from a negedge, wait (bounded) for valid.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic ov, output logic un,
                         output int lat, output logic again);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; r = '0; ov = 1'b0; un = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                lat = n; r = result; ov = overflow; un = underflow;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        again = valid;
    endtask

    task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                           input logic eo, input logic eu, input int elat);
        logic [31:0] r;
        logic ov, un, again;
        int lat;
        do_op(x, y, r, ov, un, lat, again);
        check("vec_result", 64'(r), 64'(er));
        check("vec_flags", 64'({ov, un}), 64'({eo, eu}));
        check("vec_latency", 64'(lat), 64'(elat));
        check("vec_pulse_width", 64'(again), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        int unsigned mode;
        logic [7:0]  e;
        logic [22:0] f;
        mode = $urandom_range(0, 19);
        f = 23'($urandom);
        case (mode)
            0:       begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            2, 3:    e = 8'($urandom_range(250, 254));
            4, 5:    e = 8'($urandom_range(1, 4));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    initial begin
        logic [31:0] r, x, y, r1;
        logic ov, un, again;
        logic [34:0] m;
        logic [33:0] exp_v;
        int lat, pulses;

        rst_n = 1'b1; a = '0; b = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", 64'(result), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_flags", 64'({overflow, underflow}), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_vec(32'h40628F5C, 32'h40100000, 32'h40B947AE, 0, 0, 5);
        run_vec(32'h40628F5C, 32'hC0100000, 32'h3FA51EB8, 0, 0, 5);
        run_vec(32'hC0628F5C, 32'h40100000, 32'hBFA51EB8, 0, 0, 5);
        run_vec(32'hC0628F5C, 32'hC0100000, 32'hC0B947AE, 0, 0, 5);
        run_vec(32'hC2031EB8, 32'hC4BB91EC, 32'hC4BFAAE1, 0, 0, 5);
        run_vec(32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 2);
        run_vec(32'h00000000, 32'hC0628F5C, 32'hC0628F5C, 0, 0, 2);
        run_vec(32'h40628F5C, 32'h00000000, 32'h40628F5C, 0, 0, 2);
        run_vec(32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 2);
        run_vec(32'h7F800000, 32'h7F800000, 32'h7F800000, 0, 0, 2);
        run_vec(32'h7F800000, 32'hFF800000, 32'hFF800001, 0, 0, 2);
        run_vec(32'h7F800001, 32'hFF800000, 32'hFF800001, 0, 0, 2);
        run_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0, 5);
        run_vec(32'h00000001, 32'h00000001, 32'h00000000, 0, 1, 2);
        run_vec(32'h3FC00000, 32'hBFC00000, 32'h00000000, 0, 0, 5);
        run_vec(32'h00C00000, 32'h80800000, 32'h00000000, 0, 1, 5);
        run_vec(32'h4B800000, 32'h3F800000, 32'h4B800000, 0, 0, 5);

        // A second start while in ALIGN must be ignored.
        a = 32'h40628F5C; b = 32'h40100000; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = 0; r1 = '0;
        for (int n = 3; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (valid) begin lat = n; r1 = result; break; end
        end
        check("busy_start_latency", 64'(lat), 64'd5);
        check("busy_start_result", 64'(r1), 64'h40B947AE);
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (valid) pulses++;
        end
        check("busy_start_extra_valid", 64'(pulses), 64'd0);

        // Reset while in ADD clears outputs at once and suppresses valid.
        a = 32'h40628F5C; b = 32'hC0100000; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midop_reset_result", 64'(result), 64'd0);
        check("midop_reset_valid_flags", 64'({valid, overflow, underflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); @(negedge clk);
            if (valid) pulses++;
        end
        check("midop_reset_no_valid", 64'(pulses), 64'd0);
        run_vec(32'h40628F5C, 32'h40100000, 32'h40B947AE, 0, 0, 5);

        // Random operands through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            x = rand_op();
            case ($urandom_range(0, 5))
                0:       y = x ^ 32'h80000000;
                1:       y = {~x[31], x[30:23], 23'($urandom)};
                default: y = rand_op();
            endcase
            m = ref_add(x, y);
            exp_q.push_back(m[33:0]);
            do_op(x, y, r, ov, un, lat, again);
            exp_v = exp_q.pop_front();
            check("rand_result", 64'(r), 64'(exp_v[31:0]));
            check("rand_flags", 64'({ov, un}), 64'(exp_v[33:32]));
            check("rand_latency", 64'(lat), m[34] ? 64'd2 : 64'd5);
            check("rand_pulse_width", 64'(again), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/floating_point_adder.md
Name: floating_point_adder

Overview:
- Multi-cycle IEEE-754 single-precision (binary32) adder/subtractor with a start/valid handshake.
- Sits in the arithmetic unit as a shared FP add resource.
- Accepts two operands on a one-cycle `start` pulse and returns the sum plus overflow/underflow flags.
- Arithmetic is truncating (round-toward-zero); subnormals are flushed to zero.

Parameters:
- none (fixed binary32 format: 1 sign, 8 exponent bias 127, 23 fraction)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-HIGH (name retained per codebase; asserted = 1 resets)
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- start  input  1  one-cycle request; operands sampled on the same rising edge
- result  output  32  sum, binary32; holds last value until next completion
- valid  output  1  one-cycle pulse when result/flags update
- overflow  output  1  result exponent saturated to infinity
- underflow  output  1  result flushed to zero
- Positional port order is: clk, a, b, rst_n, start, result, valid, overflow, underflow.

Behaviour:
- Reset (async, rst_n=1): state=IDLE; result=0, valid=0, overflow=0, underflow=0.
- FSM states and transitions:
  - IDLE -> UNPACK on start=1; a and b are latched internally.
  - UNPACK: classify inputs and compute exponent difference.
    - Any special case -> DONE.
    - Otherwise -> ALIGN.
  - ALIGN: shift the smaller-exponent significand right by the exponent difference. A difference of 25 or more gives zero. Shifted-out bits are discarded.
  - ADD: 25-bit add if signs are equal; otherwise subtract the smaller magnitude from the larger. Result sign is the sign of the larger magnitude.
  - NORM: leading-one detect (single-cycle priority encoder).
    - Carry: shift right 1, exponent +1.
    - Otherwise: shift left to normalize and decrement the exponent.
    - Truncate; no rounding increment.
  - DONE: drive result and flags, pulse valid=1 for exactly one cycle, then -> IDLE.
- Latency, counted from the start-sampling edge E0:
  - Special cases: valid high after edge E2.
  - Normal operands: valid high after edge E5.
  - Fixed; independent of data.
- start while not IDLE: ignored; no queueing.
- valid deasserts the cycle after DONE. result and flags hold until the next DONE.
- Special cases, evaluated in priority order:
  1. Either input NaN (exp=255, frac!=0) -> result 0xFF800001, flags 0.
  2. +inf + -inf -> 0xFF800001, flags 0.
  3. One or both inputs inf (same sign) -> that infinity, flags 0.
  4. Input with exp=0 is treated as zero. If its fraction was nonzero, underflow=1.
     - Both zero -> +0 (0x00000000); -0 + -0 -> 0x80000000.
     - One zero -> other operand passed through unchanged.
- Exact cancellation (x + -x) -> 0x00000000, flags 0.
- Overflow: normalized exponent >= 255 -> result = signed infinity (sign,0xFF,0), overflow=1.
- Underflow: normalized exponent <= 0 -> result = signed zero, underflow=1.
- overflow and underflow are never both 1.
- Reset mid-operation: aborts immediately to IDLE with all outputs 0.

Test Plan:
- 3.54 + 2.25 and sign permutations:
  - 0x40628F5C+0x40100000 -> 0x40B947AE
  - 0x40628F5C+0xC0100000 -> 0x3FA51EB8
  - 0xC0628F5C+0x40100000 -> 0xBFA51EB8
  - 0xC0628F5C+0xC0100000 -> 0xC0B947AE
  - Each valid pulses once, 5 cycles after start; flags 0.
- Truncation check: 0xC2031EB8 + 0xC4BB91EC -> 0xC4BFAAE1; 0xC4BFAAE2 is a failure.
- Zeros:
  - 0+0 -> 0x00000000
  - 0 + 0xC0628F5C -> 0xC0628F5C
  - 0x40628F5C + 0 -> 0x40628F5C
  - Each valid after 2 cycles.
- Specials:
  - 0x7F800000+0x7F800000 -> 0x7F800000
  - 0x7F800000+0xFF800000 -> 0xFF800001
  - 0x7F800001+0xFF800000 -> 0xFF800001
  - Each completes within 2 cycles, before the next start.
- Range limits:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1
  - 0x00000001+0x00000001 -> 0x00000000, underflow=1
- Control:
  - start pulsed again during ALIGN -> ignored; single valid pulse with the first result.
  - rst_n=1 asserted mid-ADD -> outputs 0 immediately, no valid pulse.
